sal_bank_fsm: RTL
=================

# sal_bank_fsm

Per-bank DRAM state tracker and timing gate for the DDR2 controller. Holds one bank's state (idle, activating, active, precharging, refreshing) and the open row. Enforces the bank-level timing parameters (tRCD, tRAS, tRTP, tWTP, tRP, tRFC) supplied by the configuration block. Publishes per-command "ok" flags to the scheduler, which instantiates one copy per bank.

## Interface
- `TW`, default 8: width of every `*_m1` timing input and of the internal counters.
- `ROW_W`, default 14: row address width.
- `clk` in 1: controller clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `t_rcd_m1`, `t_rp_m1`, `t_ras_m1`, `t_rfc_m1`, `t_rtp_m1`, `t_wtp_m1` in TW each: timing value minus one, in clock cycles.
- `act_i` in 1: scheduler issues ACTIVATE this cycle.
- `rd_i` in 1: scheduler issues READ this cycle.
- `wr_i` in 1: scheduler issues WRITE this cycle.
- `pre_i` in 1: scheduler issues PRECHARGE this cycle.
- `ref_i` in 1: scheduler issues REFRESH this cycle.
- `row_i` in ROW_W: row for ACTIVATE; also the compare row for `row_hit_o`.
- `act_ok_o` out 1: ACTIVATE legal this cycle.
- `rdwr_ok_o` out 1: READ/WRITE legal this cycle.
- `pre_ok_o` out 1: PRECHARGE legal this cycle.
- `ref_ok_o` out 1: REFRESH legal this cycle.
- `row_hit_o` out 1: bank is ACTIVE and `open_row == row_i`.
- `open_row_o` out ROW_W: latched row; reset 0.
- `err_o` out 1: registered one-cycle pulse flagging an illegal or multiple command.

## Operation
- States: IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING. Reset state is IDLE.
- Counter `main_cnt` handles tRCD, tRP and tRFC. Counter `pre_cnt` handles tRAS, tRTP and tWTP. Both reset to 0, decrement by 1 per cycle, and hold at 0 (saturate; never wrap).
- IDLE + `act_i`: accepted.
  - Latch `open_row = row_i`, load `main_cnt = t_rcd_m1` and `pre_cnt = t_ras_m1`.
  - Go to ACTIVATING.
- IDLE + `ref_i`: load `main_cnt = t_rfc_m1`, go to REFRESHING.
- ACTIVATING → ACTIVE in the cycle `main_cnt == 0`.
- ACTIVE + `rd_i`: `pre_cnt = max(pre_cnt_dec, t_rtp_m1)`, where `pre_cnt_dec` is the saturated decrement of the current value. Use the (TW+1)-free unsigned compare; equal values take either operand.
- ACTIVE + `wr_i`: same rule with `t_wtp_m1`. State stays ACTIVE.
- ACTIVE + `pre_i`: load `main_cnt = t_rp_m1`, go to PRECHARGING. `open_row_o` keeps its value.
- PRECHARGING or REFRESHING → IDLE in the cycle `main_cnt == 0`.
- Flag equations:
  - `act_ok_o = ref_ok_o = (state == IDLE)`.
  - `rdwr_ok_o = (state == ACTIVE)`.
  - `pre_ok_o = (state == ACTIVE) && (pre_cnt == 0)`.
- Timing inputs are sampled only on command acceptance. Changing them mid-count has no effect on a running count.
- Illegal command: any command whose ok flag is low, or two or more of the five command inputs high in the same cycle.
  - No state, counter or row change.
  - `err_o = 1` in the next cycle.
- While `rst` is high, all state returns to reset values at the next edge regardless of any in-flight count or command.

## Timing
- All `*_ok_o` and `row_hit_o` depend combinationally only on registers, except `row_hit_o`'s compare with `row_i`. There is no path from any command input to any output in the same cycle.
- Command accepted at edge N means the dependent flag rises at edge N + t, where t = `*_m1` + 1:
  - ACT at N gives `rdwr_ok_o` at N + t_rcd.
  - PRE at N gives `act_ok_o` at N + t_rp.
  - REF at N gives `act_ok_o` at N + t_rfc.
  - ACT at N gives `pre_ok_o` no earlier than N + t_ras.
- An `*_m1` value of 0 makes the flag rise the cycle immediately after the command.
- Reset values: `act_ok_o = 1`, `ref_ok_o = 1`, `rdwr_ok_o = 0`, `pre_ok_o = 0`, `row_hit_o = 0`, `open_row_o = 0`, `err_o = 0`.

## Structure
- Package `sal_bank_pkg` holds:
  - enum `bank_state_t` (the five states);
  - `TW` and `ROW_W` defaults;
  - a `max_tw` function.
- Sub-module `sal_sat_down_counter`, instantiated twice for `main_cnt` and `pre_cnt`:
  - load, load value, saturating decrement;
  - `is_zero` output.
- The FSM and flag logic live in `sal_bank_fsm`.

## Test plan
- Reset, then ACT row 0x12A with t_rcd_m1 = 3 → `rdwr_ok_o` rises exactly 4 cycles later. `open_row_o = 0x12A`, `row_hit_o = 1` for `row_i = 0x12A`.
- ACT with t_ras_m1 = 9, t_rtp_m1 = 3, then RD at cycle 8 after ACT → `pre_ok_o` first high at cycle 12, not 10.
- PRE with t_rp_m1 = 2 → `act_ok_o` high 3 cycles later. REF with t_rfc_m1 = 50 → idle after 51 cycles.
- RD while IDLE, and `act_i` + `ref_i` in the same cycle → `err_o` pulses 1 cycle later; state and counters unchanged.
- All `*_m1 = 0`: ACT, RD, PRE, ACT on consecutive cycles → all accepted, no `err_o`.
- Assert `rst` mid-REFRESHING → IDLE with reset output values at the next edge.

Source files
------------

// File: rtl/sal_bank_pkg.sv
// Shared types and helpers for the per-bank DRAM state tracker.
package sal_bank_pkg;

  localparam int unsigned TW_DEF    = 8;
  localparam int unsigned ROW_W_DEF = 14;
  localparam int unsigned MAX_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_ACTIVE,
    ST_PRECHARGING,
    ST_REFRESHING
  } bank_state_t;

  // Unsigned maximum; equal operands return either one.
  function automatic logic [MAX_W-1:0] max_tw(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/sal_bank_fsm_if.sv
// Scheduler <-> bank command and status bundle.
interface sal_bank_fsm_if
  import sal_bank_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF
) ();

  logic             act_i;
  logic             rd_i;
  logic             wr_i;
  logic             pre_i;
  logic             ref_i;
  logic [ROW_W-1:0] row_i;
  logic             act_ok_o;
  logic             rdwr_ok_o;
  logic             pre_ok_o;
  logic             ref_ok_o;
  logic             row_hit_o;
  logic [ROW_W-1:0] open_row_o;
  logic             err_o;

  modport master (
    output act_i, rd_i, wr_i, pre_i, ref_i, row_i,
    input  act_ok_o, rdwr_ok_o, pre_ok_o, ref_ok_o, row_hit_o, open_row_o, err_o
  );

  modport slave (
    input  act_i, rd_i, wr_i, pre_i, ref_i, row_i,
    output act_ok_o, rdwr_ok_o, pre_ok_o, ref_ok_o, row_hit_o, open_row_o, err_o
  );

endinterface

// File: rtl/sal_sat_down_counter.sv
// Loadable down counter that holds at zero instead of wrapping.
module sal_sat_down_counter #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] count,
  output logic          is_zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign is_zero = (count == '0);

endmodule

// File: rtl/sal_bank_fsm.sv
// One DRAM bank: state, open row and bank-level timing gate for the scheduler.
module sal_bank_fsm
  import sal_bank_pkg::*;
#(
  parameter int unsigned TW    = TW_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] t_rcd_m1,
  input  logic [TW-1:0] t_rp_m1,
  input  logic [TW-1:0] t_ras_m1,
  input  logic [TW-1:0] t_rfc_m1,
  input  logic [TW-1:0] t_rtp_m1,
  input  logic [TW-1:0] t_wtp_m1,
  sal_bank_fsm_if.slave bus
);

  bank_state_t      state, state_nxt;
  logic [ROW_W-1:0] open_row_q, open_row_nxt;
  logic             err_q, err_nxt;

  logic             main_load, pre_load;
  logic [TW-1:0]    main_val, pre_val, main_cnt, pre_cnt, pre_dec, turn_m1;
  logic             main_zero, pre_zero, main_last;
  logic             act_ok, rdwr_ok, pre_ok, ref_ok;
  logic [4:0]       cmd;
  logic             legal;

  sal_sat_down_counter #(.TW(TW)) u_main_cnt (
    .clk(clk), .rst(rst), .load(main_load), .load_val(main_val),
    .count(main_cnt), .is_zero(main_zero)
  );

  sal_sat_down_counter #(.TW(TW)) u_pre_cnt (
    .clk(clk), .rst(rst), .load(pre_load), .load_val(pre_val),
    .count(pre_cnt), .is_zero(pre_zero)
  );

  assign act_ok  = (state == ST_IDLE);
  assign ref_ok  = (state == ST_IDLE);
  assign rdwr_ok = (state == ST_ACTIVE);
  assign pre_ok  = (state == ST_ACTIVE) && pre_zero;

  assign cmd     = {bus.act_i, bus.rd_i, bus.wr_i, bus.pre_i, bus.ref_i};
  assign legal   = $onehot(cmd) &&
                   ((bus.act_i && act_ok) || ((bus.rd_i || bus.wr_i) && rdwr_ok) ||
                    (bus.pre_i && pre_ok) || (bus.ref_i && ref_ok));

  // Leave a timed state on the edge where main_cnt reaches zero, so an
  // *_m1 of 0 frees the dependent command on the very next cycle.
  assign main_last = main_zero || (main_cnt == TW'(1));
  assign pre_dec   = pre_zero ? '0 : pre_cnt - TW'(1);
  assign turn_m1   = bus.rd_i ? t_rtp_m1 : t_wtp_m1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      open_row_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      open_row_q <= open_row_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    open_row_nxt = open_row_q;
    err_nxt      = (cmd != '0) && !legal;
    main_load    = 1'b0;
    main_val     = t_rcd_m1;
    pre_load     = 1'b0;
    pre_val      = t_ras_m1;

    case (state)
      ST_IDLE: begin
        if (legal && bus.act_i) begin
          open_row_nxt = bus.row_i;
          main_load    = 1'b1;
          pre_load     = 1'b1;
          state_nxt    = (t_rcd_m1 == '0) ? ST_ACTIVE : ST_ACTIVATING;
        end else if (legal && bus.ref_i) begin
          main_load = 1'b1;
          main_val  = t_rfc_m1;
          state_nxt = (t_rfc_m1 == '0) ? ST_IDLE : ST_REFRESHING;
        end
      end
      ST_ACTIVATING: begin
        if (main_last) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (legal && (bus.rd_i || bus.wr_i)) begin
          pre_load = 1'b1;
          pre_val  = TW'(max_tw(MAX_W'(pre_dec), MAX_W'(turn_m1)));
        end else if (legal && bus.pre_i) begin
          main_load = 1'b1;
          main_val  = t_rp_m1;
          state_nxt = (t_rp_m1 == '0) ? ST_IDLE : ST_PRECHARGING;
        end
      end
      ST_PRECHARGING, ST_REFRESHING: begin
        if (main_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.act_ok_o   = act_ok;
  assign bus.ref_ok_o   = ref_ok;
  assign bus.rdwr_ok_o  = rdwr_ok;
  assign bus.pre_ok_o   = pre_ok;
  assign bus.row_hit_o  = (state == ST_ACTIVE) && (open_row_q == bus.row_i);
  assign bus.open_row_o = open_row_q;
  assign bus.err_o      = err_q;

endmodule
